// File: rtl/mem_display_ctrl.sv
// Memory display controller: the CPU owns the data memory until "finish", then words are read back for display.
// Optional build macro MEM_DISPLAY_CTRL_DEBOUNCE_EN adds a DB_CYCLES stability filter on each button.
module mem_display_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0004,
    parameter logic [31:0] LIMIT_ADDR = 32'h0000_03FC,
    parameter int          DB_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_finish,
    input  logic        btn_next,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_stall,
    output logic [15:0] disp_value,
    output logic        disp_valid,
    output logic [31:0] disp_addr,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_FETCH = 2'd2,
        S_SHOW  = 2'd3
    } state_t;

    localparam logic [31:0] BASE_AL = {BASE_ADDR[31:2], 2'b00};

    // Bit 0 is finish, bit 1 is next.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] fill_q;
    logic [1:0] prev_q;
    logic [1:0] armed_q;
    logic [1:0] btn_lvl;
    logic [1:0] btn_pulse;

    assign btn_raw = {btn_next, btn_finish};

`ifdef MEM_DISPLAY_CTRL_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    logic [1:0]    filt_q;
    logic [CW-1:0] db_cnt_q [2];

    // The filtered level only follows the synchronised one after DB_CYCLES disagreeing cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    filt_q[i]   <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign btn_lvl = filt_q;
`else
    assign btn_lvl = sync2_q;
`endif

    // armed_q blocks a pulse until a genuine low sample has been seen, so a button held through reset is inert.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fill_q  <= '0;
            prev_q  <= '0;
            armed_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            prev_q  <= btn_lvl;
            armed_q <= armed_q | ({2{fill_q[1]}} & ~sync2_q);
        end
    end

    assign btn_pulse = btn_lvl & ~prev_q & armed_q;

    state_t      state_q;
    logic [31:0] disp_addr_q;
    logic [15:0] disp_value_q;
    logic        disp_valid_q;
    logic [32:0] addr_inc;
    logic [31:0] addr_step_d;

    assign addr_inc    = {1'b0, disp_addr_q} + 33'd4;
    assign addr_step_d = (addr_inc > {1'b0, LIMIT_ADDR}) ? BASE_AL : addr_inc[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_RUN;
            disp_addr_q  <= BASE_AL;
            disp_value_q <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (btn_pulse[0]) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    disp_addr_q <= BASE_AL;
                    state_q     <= S_FETCH;
                end
                S_FETCH: begin
                    disp_value_q <= mem_rdata[15:0];
                    disp_valid_q <= 1'b1;
                    state_q      <= S_SHOW;
                end
                S_SHOW: begin
                    // Finish takes priority; a simultaneous next is dropped.
                    if (btn_pulse[0]) begin
                        disp_addr_q  <= BASE_AL;
                        disp_valid_q <= 1'b0;
                        state_q      <= S_FETCH;
                    end else if (btn_pulse[1]) begin
                        disp_addr_q  <= addr_step_d;
                        disp_valid_q <= 1'b0;
                        state_q      <= S_FETCH;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = disp_addr_q;
        mem_wdata = '0;
        case (state_q)
            S_RUN: begin
                mem_read  = cpu_mem_read;
                mem_write = cpu_mem_write;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            S_FETCH: mem_read = 1'b1;
            default: ;
        endcase
    end

    logic unused_rdata_hi;
    assign unused_rdata_hi = ^mem_rdata[31:16];

    assign cpu_stall   = (state_q != S_RUN);
    assign disp_value  = disp_value_q;
    assign disp_valid  = disp_valid_q;
    assign disp_addr   = disp_addr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_display_ctrl.sv
// Bench for mem_display_ctrl: random and directed button/CPU activity against a cycle-level display model.
module tb_mem_display_ctrl;

    localparam logic [31:0] BASE  = 32'h0000_0004;
    localparam logic [31:0] LIMIT = 32'h0000_000C;
    localparam int          DB    = 4;
`ifdef MEM_DISPLAY_CTRL_DEBOUNCE_EN
    localparam int LAT    = DB + 2;
    localparam int MINRUN = DB + 1;
`else
    localparam int LAT    = 2;
    localparam int MINRUN = 1;
`endif

    logic        clk, reset, btn_finish, btn_next;
    logic        cpu_mem_read, cpu_mem_write;
    logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
    logic        mem_read, mem_write, cpu_stall, disp_valid;
    logic [31:0] mem_addr, mem_wdata, disp_addr;
    logic [15:0] disp_value;
    logic [1:0]  dbg_state;

    logic [31:0] mem [16];
    assign mem_rdata = mem[mem_addr[5:2]];

    mem_display_ctrl #(.BASE_ADDR(BASE), .LIMIT_ADDR(LIMIT), .DB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .btn_finish(btn_finish), .btn_next(btn_next),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_stall(cpu_stall), .disp_value(disp_value), .disp_valid(disp_valid),
        .disp_addr(disp_addr), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 run, 1 drain, 2 fetch, 3 show. A press takes effect LAT+1 edges after its rise.
    int          m_ph;
    logic [31:0] m_addr;
    logic [15:0] m_val;
    logic        hf [0:31];
    logic        hn [0:31];
    logic        fp, np;
    logic        next_mask = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph   = 0;
            m_addr = BASE;
            m_val  = 16'h0;
            for (int i = 0; i < 32; i++) begin
                hf[i] = 1'b1;
                hn[i] = 1'b1;
            end
        end else begin
            for (int i = 31; i > 0; i--) begin
                hf[i] = hf[i-1];
                hn[i] = hn[i-1];
            end
            hf[0] = btn_finish;
            hn[0] = btn_next & ~next_mask;
            fp = hf[LAT] & ~hf[LAT+1];
            np = hn[LAT] & ~hn[LAT+1];
            case (m_ph)
                0: if (fp) m_ph = 1;
                1: begin m_addr = BASE; m_ph = 2; end
                2: begin m_val = mem[m_addr[5:2]][15:0]; m_ph = 3; end
                default: begin
                    if (fp) begin
                        m_addr = BASE;
                        m_ph   = 2;
                    end else if (np) begin
                        m_addr = (m_addr + 32'd4 > LIMIT) ? BASE : m_addr + 32'd4;
                        m_ph   = 2;
                    end
                end
            endcase
        end
    end

    int          fetch_cnt = 0;
    logic [31:0] last_fetch_addr = '0;

    always @(posedge clk) begin
        #2;
        if (!reset) begin
            check("disp_addr",  disp_addr, m_addr);
            check("disp_value", {16'h0, disp_value}, {16'h0, m_val});
            check("disp_valid", {31'h0, disp_valid}, {31'h0, m_ph == 3});
            check("cpu_stall",  {31'h0, cpu_stall}, {31'h0, m_ph != 0});
            if (m_ph == 0) begin
                check("run_mem_read",  {31'h0, mem_read}, {31'h0, cpu_mem_read});
                check("run_mem_write", {31'h0, mem_write}, {31'h0, cpu_mem_write});
                check("run_mem_addr",  mem_addr, cpu_addr);
                check("run_mem_wdata", mem_wdata, cpu_wdata);
            end else begin
                check("own_mem_write", {31'h0, mem_write}, 32'h0);
                check("own_mem_read",  {31'h0, mem_read}, {31'h0, m_ph == 2});
                if (m_ph == 2) begin
                    check("fetch_addr",  mem_addr, m_addr);
                    check("fetch_wdata", mem_wdata, 32'h0);
                end
            end
            if (cpu_stall && mem_read) begin
                fetch_cnt++;
                last_fetch_addr = mem_addr;
            end
        end
    end

    task automatic rand_cpu();
        cpu_mem_read  = 1'($urandom_range(1, 0));
        cpu_mem_write = 1'($urandom_range(1, 0));
        cpu_addr      = $urandom & 32'h0000_FFFC;
        cpu_wdata     = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic f, input logic n, input int hold);
        @(negedge clk);
        btn_finish = f;
        btn_next   = n;
        idle(hold);
        btn_finish = 1'b0;
        btn_next   = 1'b0;
        idle(LAT + MINRUN + 8);
    endtask

    // Buttons toggle with random run lengths; finish can be excluded to stay in RUN.
    task automatic run_random(input int cycles, input bit use_finish);
        int rf, rn;
        rf = $urandom_range(8, MINRUN);
        rn = $urandom_range(8, MINRUN);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rand_cpu();
            if (--rf == 0) begin
                if (use_finish) btn_finish = ~btn_finish;
                rf = $urandom_range(8, MINRUN);
            end
            if (--rn == 0) begin
                btn_next = ~btn_next;
                rn = $urandom_range(8, MINRUN);
            end
        end
        @(negedge clk);
        btn_finish = 1'b0;
        btn_next   = 1'b0;
        idle(LAT + MINRUN + 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[1] = 32'h0000_1234;
        mem[2] = 32'h5A5A_BEEF;
        mem[3] = 32'h0000_CAFE;
        reset = 1'b0; btn_finish = 1'b0; btn_next = 1'b0;
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_cpu_stall",  {31'h0, cpu_stall}, 32'h0);
        check("rst_disp_valid", {31'h0, disp_valid}, 32'h0);
        check("rst_disp_value", {16'h0, disp_value}, 32'h0);
        check("rst_disp_addr",  disp_addr, 32'h4);
        idle(3);
        reset = 1'b0;
        idle(LAT + MINRUN + 4);

        run_random(40, 1'b0);

        @(negedge clk);
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hABCD;
        #1;
        check("pass_mem_write", {31'h0, mem_write}, 32'h1);
        check("pass_mem_addr",  mem_addr, 32'h10);
        check("pass_mem_wdata", mem_wdata, 32'hABCD);
        check("pass_cpu_stall", {31'h0, cpu_stall}, 32'h0);

        press(1'b1, 1'b0, MINRUN + 1);
        check("finish_fetch_addr", last_fetch_addr, 32'h4);
        check("finish_value", {16'h0, disp_value}, 32'h1234);
        check("finish_valid", {31'h0, disp_valid}, 32'h1);
        check("finish_stall", {31'h0, cpu_stall}, 32'h1);

        press(1'b0, 1'b1, MINRUN + 1);
        check("step1_addr",  disp_addr, 32'h8);
        check("step1_value", {16'h0, disp_value}, 32'hBEEF);
        press(1'b0, 1'b1, MINRUN + 1);
        check("step2_addr",  disp_addr, 32'hC);
        check("step2_value", {16'h0, disp_value}, 32'hCAFE);
        press(1'b0, 1'b1, MINRUN + 1);
        check("wrap_addr",   disp_addr, 32'h4);
        check("wrap_value",  {16'h0, disp_value}, 32'h1234);
        press(1'b0, 1'b1, MINRUN + 1);
        check("pre_coll_addr", disp_addr, 32'h8);

        fetch_cnt = 0;
        press(1'b1, 1'b1, MINRUN + 1);
        check("coll_addr",    disp_addr, 32'h4);
        check("coll_fetches", fetch_cnt, 32'd1);

`ifdef MEM_DISPLAY_CTRL_DEBOUNCE_EN
        next_mask = 1'b1;
        @(negedge clk);
        btn_next = 1'b1;
        idle(3);
        btn_next = 1'b0;
        idle(DB + 10);
        next_mask = 1'b0;
        check("glitch_addr", disp_addr, 32'h4);
        fetch_cnt = 0;
        press(1'b0, 1'b1, 10);
        check("db_step_addr",    disp_addr, 32'h8);
        check("db_step_fetches", fetch_cnt, 32'd1);
`endif

        run_random(400, 1'b1);

        press(1'b0, 1'b1, MINRUN + 1);
        check("pre_rst_valid", {31'h0, disp_valid}, 32'h1);
        @(negedge clk);
        cpu_mem_read = 1'b1; cpu_mem_write = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_stall",    {31'h0, cpu_stall}, 32'h0);
        check("mid_rst_valid",    {31'h0, disp_valid}, 32'h0);
        check("mid_rst_value",    {16'h0, disp_value}, 32'h0);
        check("mid_rst_addr",     disp_addr, 32'h4);
        check("mid_rst_mem_read", {31'h0, mem_read}, 32'h1);

        btn_finish = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(LAT + MINRUN + 12);
        check("held_btn_no_pulse", {31'h0, cpu_stall}, 32'h0);
        btn_finish = 1'b0;
        idle(LAT + MINRUN + 4);
        press(1'b1, 1'b0, MINRUN + 1);
        check("refinish_value", {16'h0, disp_value}, 32'h1234);
        check("refinish_valid", {31'h0, disp_valid}, 32'h1);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
